// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer between the core data port and dmem.
package store_buffer_pkg;

    localparam int SB_AW  = 32;
    localparam int SB_DW  = 32;
    localparam int SB_WAW = SB_AW - 2;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] wdata;
        logic             sb;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue: entry storage, head/tail/count bookkeeping and a per-entry
// word-address match vector used by the load-hit detector.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  sb_entry_t         push_entry_i,
    input  logic              pop_i,
    input  logic [SB_WAW-1:0] cmp_word_i,
    output sb_entry_t         head_entry_o,
    output logic [CW-1:0]     count_o,
    output logic [DEPTH-1:0]  match_o
);

    sb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] offset [DEPTH];

    always_comb begin
        head_d  = pop_i  ? head_q + PW'(1) : head_q;
        tail_d  = push_i ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: validity is implied by head/count alone.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    // Slot i is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        match_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset[i]  = PW'(i) - head_q;
            match_o[i] = ({1'b0, offset[i]} < count_q) &&
                         (mem_q[i].addr[SB_AW-1:2] == cmp_word_i);
        end
    end

    assign head_entry_o = mem_q[head_q];
    assign count_o      = count_q;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: stores retire into sb_fifo and drain to dmem whenever the
// core is not loading; loads that hit a pending store stall while the drain runs.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_sb,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic          mem_we,
    output logic          mem_sb,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          empty
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    sb_entry_t        push_entry;
    sb_entry_t        head_entry;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] match;
    logic             full;
    logic             not_empty;
    logic             load_hit;
    logic             push;
    logic             drain;

    assign push_entry = '{addr: cpu_addr, wdata: cpu_wdata, sb: cpu_sb};

    assign full      = (count == FULL_CNT);
    assign not_empty = (count != '0);
    assign load_hit  = cpu_re && (|match);
    // A hitting load yields the shared port to the drain so the hit clears.
    assign drain     = not_empty && (!cpu_re || load_hit);
    assign push      = cpu_we && !full;

    assign cpu_stall = (cpu_we && full) || load_hit;
    assign cpu_rdata = mem_rdata;
    assign empty     = !not_empty;

    assign mem_we    = drain;
    assign mem_sb    = drain && head_entry.sb;
    assign mem_addr  = drain ? head_entry.addr  : cpu_addr;
    assign mem_wdata = drain ? head_entry.wdata : '0;

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (drain),
        .cmp_word_i   (cpu_addr[AW-1:2]),
        .head_entry_o (head_entry),
        .count_o      (count),
        .match_o      (match)
    );

    a_no_store_with_load: assert property (
        @(posedge clk) disable iff (!reset) !(cpu_we && cpu_re)
    );

    a_hit_drains: assert property (
        @(posedge clk) disable iff (!reset) load_hit |-> mem_we
    );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// against a queue-based model of pending stores and a golden memory image.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        cpu_we    = 1'b0;
    logic        cpu_sb    = 1'b0;
    logic        cpu_re    = 1'b0;
    logic [31:0] cpu_addr  = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_we;
    logic        mem_sb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        empty;

    int errors   = 0;
    int checks   = 0;
    int timeouts = 0;
    int wr_count = 0;

    logic [64:0] exp_q[$];
    logic [31:0] dmem [256];
    logic [31:0] gold [256];

    logic        m_hit, m_drain, m_stall;
    int          m_sz;
    logic [31:0] m_addr;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_sb    (cpu_sb),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_we    (mem_we),
        .mem_sb    (mem_sb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .empty     (empty)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [31:0] d, input logic sb);
        logic [31:0] r;
        r = old;
        if (!sb) r = d;
        else     r[8*a[1:0] +: 8] = d[7:0];
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i] = '0;
            gold[i] = '0;
        end
    end

    // Environment dmem: written only by what the DUT presents on mem_*.
    assign mem_rdata = dmem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (reset && mem_we) begin
            dmem[mem_addr[9:2]] <= merge(dmem[mem_addr[9:2]], mem_addr, mem_wdata, mem_sb);
            wr_count <= wr_count + 1;
        end
    end

    always @(negedge reset) exp_q.delete();

    // Reference model: pending stores as a plain queue, checked every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            m_sz  = exp_q.size();
            m_hit = 1'b0;
            if (cpu_re)
                foreach (exp_q[i]) if (exp_q[i][63:34] == cpu_addr[31:2]) m_hit = 1'b1;
            m_drain = (m_sz > 0) && (!cpu_re || m_hit);
            m_stall = (cpu_we && m_sz == DEPTH) || m_hit;
            m_addr  = m_drain ? exp_q[0][63:32] : cpu_addr;
            checks++;
            if (cpu_stall !== m_stall) begin
                errors++;
                $display("FAIL mon_stall t=%0t got=%0b exp=%0b", $time, cpu_stall, m_stall);
            end
            checks++;
            if (mem_we !== m_drain) begin
                errors++;
                $display("FAIL mon_mem_we t=%0t got=%0b exp=%0b", $time, mem_we, m_drain);
            end
            checks++;
            if (empty !== (m_sz == 0)) begin
                errors++;
                $display("FAIL mon_empty t=%0t got=%0b exp=%0b", $time, empty, m_sz == 0);
            end
            checks++;
            if (mem_addr !== m_addr) begin
                errors++;
                $display("FAIL mon_mem_addr t=%0t got=%h exp=%h", $time, mem_addr, m_addr);
            end
            if (m_drain) begin
                checks++;
                if (mem_wdata !== exp_q[0][31:0] || mem_sb !== exp_q[0][64]) begin
                    errors++;
                    $display("FAIL mon_drain_data t=%0t got=%h/%0b exp=%h/%0b", $time,
                             mem_wdata, mem_sb, exp_q[0][31:0], exp_q[0][64]);
                end
            end
            if (cpu_re && !m_hit) begin
                checks++;
                if (cpu_rdata !== gold[cpu_addr[9:2]]) begin
                    errors++;
                    $display("FAIL mon_rdata t=%0t addr=%h got=%h exp=%h", $time,
                             cpu_addr, cpu_rdata, gold[cpu_addr[9:2]]);
                end
            end
            if (m_drain) begin
                gold[exp_q[0][41:34]] = merge(gold[exp_q[0][41:34]], exp_q[0][63:32],
                                              exp_q[0][31:0], exp_q[0][64]);
                void'(exp_q.pop_front());
            end
            if (cpu_we && m_sz < DEPTH) exp_q.push_back({cpu_sb, cpu_addr, cpu_wdata});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic sb, input logic re,
                         input logic [31:0] addr, input logic [31:0] data);
        cpu_we    = we;
        cpu_sb    = sb;
        cpu_re    = re;
        cpu_addr  = addr;
        cpu_wdata = data;
    endtask

    // Issue one request and hold it while stalled, as the core would.
    task automatic issue(input logic we, input logic sb, input logic re,
                         input logic [31:0] addr, input logic [31:0] data);
        int n;
        next_cycle();
        drive(we, sb, re, addr, data);
        @(negedge clk);
        n = 0;
        while (cpu_stall && n < 16) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        if (cpu_stall) timeouts++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || cpu_stall !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got we=%0b stall=%0b empty=%0b exp 0/0/1",
                     mem_we, cpu_stall, empty);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_empty got=%0b exp=1", empty);
        end
    endtask

    task automatic test_single_drain();
        issue(1'b1, 1'b0, 1'b0, 32'h40, 32'h11223344);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h11223344) begin
            errors++;
            $display("FAIL single_drain got we=%0b addr=%h data=%h exp 1/00000040/11223344",
                     mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL single_after got empty=%0b we=%0b exp 1/0", empty, mem_we);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [5];
        int start;
        start = wr_count;
        for (int k = 0; k < 5; k++) begin
            data[k] = $urandom;
            issue(1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * k), data[k]);
            issue(1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
        end
        idle(3);
        checks++;
        if (wr_count - start !== 5) begin
            errors++;
            $display("FAIL b2b_write_count got=%0d exp=5", wr_count - start);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dmem[64 + k] !== data[k]) begin
                errors++;
                $display("FAIL b2b_dmem[%0d] got=%h exp=%h", k, dmem[64 + k], data[k]);
            end
        end
        checks++;
        if (timeouts !== 0) begin
            errors++;
            $display("FAIL b2b_stall_timeout got=%0d exp=0", timeouts);
            timeouts = 0;
        end
    endtask

    task automatic test_byte_hit();
        issue(1'b1, 1'b1, 1'b0, 32'h43, 32'h000000AB);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b1 || mem_we !== 1'b1 || mem_sb !== 1'b1 || mem_addr !== 32'h43) begin
            errors++;
            $display("FAIL byte_hit_drain got stall=%0b we=%0b sb=%0b addr=%h exp 1/1/1/00000043",
                     cpu_stall, mem_we, mem_sb, mem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_we !== 1'b0 || cpu_rdata !== 32'hAB223344) begin
            errors++;
            $display("FAIL byte_hit_load got stall=%0b we=%0b rdata=%h exp 0/0/ab223344",
                     cpu_stall, mem_we, cpu_rdata);
        end
    endtask

    task automatic test_load_miss();
        issue(1'b1, 1'b0, 1'b0, 32'h40, 32'h55667788);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 32'h80, 32'h0);
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h80 || empty !== 1'b0) begin
            errors++;
            $display("FAIL miss_load got stall=%0b we=%0b addr=%h empty=%0b exp 0/0/00000080/0",
                     cpu_stall, mem_we, mem_addr, empty);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h55667788) begin
            errors++;
            $display("FAIL miss_drain got we=%0b addr=%h data=%h exp 1/00000040/55667788",
                     mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 0; k < 3; k++) issue(1'b1, 1'b0, 1'b0, 32'h140 + 32'(4 * k), 32'hC0DE0000 + k);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (mem_we !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL midrain_before got we=%0b empty=%0b exp 1/0", mem_we, empty);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || empty !== 1'b1 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL midrain_reset got we=%0b empty=%0b stall=%0b exp 0/1/0",
                     mem_we, empty, cpu_stall);
        end
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || empty !== 1'b1) begin
                errors++;
                $display("FAIL midrain_after[%0d] got we=%0b empty=%0b exp 0/1", k, mem_we, empty);
            end
        end
        checks++;
        if (dmem[82] !== 32'h0) begin
            errors++;
            $display("FAIL midrain_discard got=%h exp=00000000", dmem[82]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] data [2*DEPTH+1];
        int start;
        start = wr_count;
        for (int k = 0; k < 2 * DEPTH + 1; k++) begin
            data[k] = $urandom;
            issue(1'b1, 1'b0, 1'b0, 32'h180 + 32'(4 * k), data[k]);
        end
        idle(2);
        checks++;
        if (wr_count - start !== 2 * DEPTH + 1) begin
            errors++;
            $display("FAIL wrap_write_count got=%0d exp=%0d", wr_count - start, 2 * DEPTH + 1);
        end
        for (int k = 0; k < 2 * DEPTH + 1; k++) begin
            checks++;
            if (dmem[96 + k] !== data[k]) begin
                errors++;
                $display("FAIL wrap_dmem[%0d] got=%h exp=%h", k, dmem[96 + k], data[k]);
            end
        end
    endtask

    task automatic test_random();
        int op;
        logic [31:0] a;
        logic sb;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 2);
            sb = 1'(($urandom_range(0, 1)));
            a  = 32'h300 + 32'(4 * $urandom_range(0, 7));
            if (op == 0)      issue(1'b1, sb, 1'b0, sb ? a + 32'($urandom_range(0, 3)) : a, $urandom);
            else if (op == 1) issue(1'b0, 1'b0, 1'b1, a, 32'h0);
            else              issue(1'b0, 1'b0, 1'b0, a, 32'h0);
        end
        idle(3);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL random_final_empty got=%0b exp=1", empty);
        end
        checks++;
        if (timeouts !== 0) begin
            errors++;
            $display("FAIL random_stall_timeout got=%0d exp=0", timeouts);
        end
    endtask

    initial begin
        test_reset();
        test_single_drain();
        test_back_to_back();
        test_byte_hit();
        test_load_miss();
        test_reset_mid_drain();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
